// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: recovers pixel coordinates, line/frame totals and lock state from VGA syncs.
// Define VGA_RX_FRAME_CRC_EN to add frame_crc, a CRC-16-CCITT over each frame's active pixels.
module vga_timing_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic [9:0]  h_total_meas,
    output logic [9:0]  v_total_meas,
    output logic        timing_err
`ifdef VGA_RX_FRAME_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [9:0] H_TOTAL_L = 10'(H_TOTAL);
    localparam logic [9:0] V_TOTAL_L = 10'(V_TOTAL);
    localparam logic [9:0] H_START   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [2:0] LOCK_N    = 3'(LOCK_FRAMES);

    logic        hsync_p0, hsync_p1, vsync_p0, vsync_p1;
    logic [11:0] rgb_p0, rgb_p1;
    logic        hsync_prev, vsync_prev;
    logic [9:0]  h_cnt, v_cnt;
    logic        vfall_pend, h_armed;
    logic [1:0]  state;
    logic [2:0]  good_cnt;

    logic hfall, vfall, frame_bnd, in_active;
    logic line_err, frame_err, h_sat_err, v_sat_err, any_err;

    // Stage p0/p1: two-flop synchronizers, clocked every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p0 <= 1'b1;
            hsync_p1 <= 1'b1;
            vsync_p0 <= 1'b1;
            vsync_p1 <= 1'b1;
            rgb_p0   <= '0;
            rgb_p1   <= '0;
        end else begin
            hsync_p0 <= hsync_in;
            hsync_p1 <= hsync_p0;
            vsync_p0 <= vsync_in;
            vsync_p1 <= vsync_p0;
            rgb_p0   <= rgb_in;
            rgb_p1   <= rgb_p0;
        end
    end

    always_comb begin
        hfall     = pix_en && !hsync_p1 && hsync_prev;
        vfall     = pix_en && !vsync_p1 && vsync_prev;
        frame_bnd = hfall && (vfall_pend || vfall);
        in_active = (h_cnt >= H_START) && (h_cnt < H_END) &&
                    (v_cnt >= V_START) && (v_cnt < V_END);
        line_err  = hfall && h_armed && ((h_cnt + 10'd1) != H_TOTAL_L);
        frame_err = frame_bnd && (state != ST_SEARCH) && ((v_cnt + 10'd1) != V_TOTAL_L);
        // Flag the step into saturation only once; a held 1023 is already reported
        h_sat_err = pix_en && !hfall && (h_cnt == CNT_MAX - 10'd1);
        v_sat_err = hfall && !frame_bnd && (v_cnt == CNT_MAX - 10'd1);
        any_err   = line_err || frame_err || h_sat_err || v_sat_err;
    end

    // Stage p2: counters, measurements and aligned pixel outputs on pix_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_prev   <= 1'b1;
            vsync_prev   <= 1'b1;
            h_cnt        <= '0;
            v_cnt        <= '0;
            vfall_pend   <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_valid    <= 1'b0;
            rgb_out      <= '0;
        end else if (pix_en) begin
            hsync_prev <= hsync_p1;
            vsync_prev <= vsync_p1;
            if (hfall) begin
                h_cnt        <= '0;
                h_total_meas <= h_cnt + 10'd1;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (hfall)      vfall_pend <= 1'b0;
            else if (vfall) vfall_pend <= 1'b1;
            if (frame_bnd) begin
                v_cnt        <= '0;
                v_total_meas <= v_cnt + 10'd1;
            end else if (hfall && v_cnt != CNT_MAX) begin
                v_cnt <= v_cnt + 10'd1;
            end
            pix_valid <= in_active;
            pix_x     <= in_active ? h_cnt - H_START : '0;
            pix_y     <= in_active ? v_cnt - V_START : '0;
            rgb_out   <= rgb_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
            h_armed  <= 1'b0;
        end else if (any_err) begin
            state    <= ST_SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
            h_armed  <= 1'b0;
        end else if (pix_en) begin
            if (hfall) h_armed <= 1'b1;
            if (frame_bnd) begin
                case (state)
                    ST_SEARCH: begin
                        state    <= ST_TRACK;
                        good_cnt <= '0;
                    end
                    ST_TRACK: begin
                        good_cnt <= good_cnt + 3'd1;
                        if (good_cnt + 3'd1 == LOCK_N) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timing_err  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            timing_err  <= any_err;
            frame_start <= frame_bnd;
        end
    end

`ifdef VGA_RX_FRAME_CRC_EN
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [11:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 11; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    logic [15:0] crc_acc;

    // Accumulates exactly the samples that become pix_valid on rgb_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc   <= 16'hFFFF;
            frame_crc <= '0;
        end else if (pix_en) begin
            if (frame_bnd) begin
                frame_crc <= crc_acc;
                crc_acc   <= 16'hFFFF;
            end else if (in_active) begin
                crc_acc <= crc16_step(crc_acc, rgb_p1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Randomized bench for vga_timing_receiver on a reduced raster, checked against a sample-level model.
module tb_vga_timing_receiver;

    localparam int HT = 40, HS = 4, HBP = 3, HA = 30;
    localparam int VT = 12, VS = 2, VBP = 2, VA = 7;
    localparam int LOCKN = 2;

    logic        clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1;
    logic [11:0] rgb_in = '0;
    logic [9:0]  pix_x, pix_y, h_total_meas, v_total_meas;
    logic        pix_valid, frame_start, locked, timing_err;
    logic [11:0] rgb_out;
`ifdef VGA_RX_FRAME_CRC_EN
    logic [15:0] frame_crc;
`endif

    vga_timing_receiver #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .rgb_out(rgb_out),
        .frame_start(frame_start), .locked(locked), .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas), .timing_err(timing_err)
`ifdef VGA_RX_FRAME_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    always #10 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: position since the last seen sync fall, lines since the last frame boundary
    int          m_pos, m_line, m_mode, m_good;
    bit          m_phs, m_pvs, m_pend, m_harm;
    logic [15:0] m_crc;
    logic        d_hs, d_vs;
    logic [11:0] d_rgb;
    logic [9:0]  e_x, e_y, e_hm, e_vm;
    logic [11:0] e_rgb;
    logic        e_valid, e_fs, e_err, e_locked;
    logic [15:0] e_crc;

    int          n_err_pulse, n_fs, lock_rise_at, n_valid, mark_x, mark_y;
    bit          prev_locked, const_zero;
    logic [9:0]  hm_at_err;
    logic        locked_at_err;
    logic [15:0] crc_hist [$];

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            r = r ^ {d[i], 15'b0};
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [11:0] rand_rgb();
        logic [11:0] r;
        r = 12'($urandom_range(0, 4095));
        if (r == 12'hABC) r = 12'h123;
        return r;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_line = 0; m_mode = 0; m_good = 0;
        m_phs = 1; m_pvs = 1; m_pend = 0; m_harm = 0; m_crc = 16'hFFFF;
        d_hs = 1; d_vs = 1; d_rgb = '0;
        e_x = '0; e_y = '0; e_hm = '0; e_vm = '0; e_rgb = '0;
        e_valid = 0; e_fs = 0; e_err = 0; e_locked = 0; e_crc = '0;
        prev_locked = 0;
    endtask

    task automatic model_step(input logic hs, input logic vs, input logic [11:0] rgb);
        bit hf, vf, fb, err;
        int xo, yo;
        hf = !hs && m_phs;
        vf = !vs && m_pvs;
        m_phs = hs;
        m_pvs = vs;
        xo = m_pos - (HS + HBP);
        yo = m_line - (VS + VBP);
        e_valid = (xo >= 0 && xo < HA && yo >= 0 && yo < VA);
        e_x = e_valid ? 10'(xo) : 10'd0;
        e_y = e_valid ? 10'(yo) : 10'd0;
        e_rgb = rgb;
        fb = hf && (m_pend || vf);
        err = 0;
        if (hf) begin
            if (m_harm && m_pos + 1 != HT) err = 1;
            e_hm = 10'((m_pos + 1) % 1024);
            m_harm = 1;
            m_pos = 0;
        end else begin
            if (m_pos + 1 == 1023) err = 1;
            if (m_pos < 1023) m_pos++;
        end
        if (fb) begin
            if (m_mode != 0 && m_line + 1 != VT) err = 1;
            e_vm = 10'((m_line + 1) % 1024);
            m_line = 0;
        end else if (hf) begin
            if (m_line + 1 == 1023) err = 1;
            if (m_line < 1023) m_line++;
        end
        if (hf) m_pend = 0;
        else if (vf) m_pend = 1;
        if (fb) begin
            e_crc = m_crc;
            m_crc = 16'hFFFF;
        end else if (e_valid) begin
            m_crc = crc_ref(m_crc, rgb);
        end
        if (err) begin
            m_mode = 0; m_good = 0; m_harm = 0;
        end else if (fb) begin
            if (m_mode == 0) begin
                m_mode = 1; m_good = 0;
            end else if (m_mode == 1) begin
                m_good++;
                if (m_good == LOCKN) m_mode = 2;
            end
        end
        e_fs = fb;
        e_err = err;
        e_locked = (m_mode == 2);
    endtask

    task automatic drive_px(input logic hs, input logic vs, input logic [11:0] rgb);
        @(negedge clk);
        model_step(d_hs, d_vs, d_rgb);
        d_hs = hs; d_vs = vs; d_rgb = rgb;
        pix_en = 1; hsync_in = hs; vsync_in = vs; rgb_in = rgb;
        @(negedge clk);
        pix_en = 0;
        checks++; if (pix_x !== e_x) begin errors++; $display("FAIL pix_x: got %0d expected %0d", pix_x, e_x); end
        checks++; if (pix_y !== e_y) begin errors++; $display("FAIL pix_y: got %0d expected %0d", pix_y, e_y); end
        checks++; if (pix_valid !== e_valid) begin errors++; $display("FAIL pix_valid: got %b expected %b", pix_valid, e_valid); end
        checks++; if (rgb_out !== e_rgb) begin errors++; $display("FAIL rgb_out: got %h expected %h", rgb_out, e_rgb); end
        checks++; if (frame_start !== e_fs) begin errors++; $display("FAIL frame_start: got %b expected %b", frame_start, e_fs); end
        checks++; if (timing_err !== e_err) begin errors++; $display("FAIL timing_err: got %b expected %b", timing_err, e_err); end
        checks++; if (locked !== e_locked) begin errors++; $display("FAIL locked: got %b expected %b", locked, e_locked); end
        checks++; if (h_total_meas !== e_hm) begin errors++; $display("FAIL h_total_meas: got %0d expected %0d", h_total_meas, e_hm); end
        checks++; if (v_total_meas !== e_vm) begin errors++; $display("FAIL v_total_meas: got %0d expected %0d", v_total_meas, e_vm); end
`ifdef VGA_RX_FRAME_CRC_EN
        checks++; if (frame_crc !== e_crc) begin errors++; $display("FAIL frame_crc: got %h expected %h", frame_crc, e_crc); end
        if (frame_start) crc_hist.push_back(frame_crc);
`endif
        if (timing_err) begin
            n_err_pulse++;
            hm_at_err = h_total_meas;
            locked_at_err = locked;
        end
        if (frame_start) n_fs++;
        if (locked && !prev_locked && lock_rise_at < 0) lock_rise_at = n_fs;
        prev_locked = locked;
        if (pix_valid) n_valid++;
        if (pix_valid && rgb_out == 12'hABC) begin
            mark_x = int'(pix_x);
            mark_y = int'(pix_y);
        end
        @(posedge clk); #1;
        checks++;
        if (timing_err !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got err=%b fs=%b expected 0 0", timing_err, frame_start);
        end
    endtask

    task automatic drive_line(input int l, input int len, input int npix, input bit mark);
        logic [11:0] c;
        for (int p = 0; p < npix && p < len; p++) begin
            c = const_zero ? 12'h000 : rand_rgb();
            if (mark && l == VS + VBP && p == HS + HBP + 1) c = 12'hABC;
            drive_px(!(p < HS), !(l < VS), c);
        end
    endtask

    task automatic drive_frame(input int short_l, input bit mark);
        for (int l = 0; l < VT; l++) drive_line(l, (l == short_l) ? HT - 1 : HT, HT, mark);
    endtask

    task automatic clear_obs();
        n_err_pulse = 0; n_fs = 0; lock_rise_at = -1; n_valid = 0;
        mark_x = -1; mark_y = -1; hm_at_err = '0; locked_at_err = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #35;
        checks++; if (pix_x !== 0 || pix_y !== 0) begin errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", pix_x, pix_y); end
        checks++; if (pix_valid !== 0 || rgb_out !== 0) begin errors++; $display("FAIL reset_pix: got %b,%h expected 0,0", pix_valid, rgb_out); end
        checks++; if (locked !== 0 || timing_err !== 0 || frame_start !== 0) begin errors++; $display("FAIL reset_ctl: got %b%b%b expected 000", locked, timing_err, frame_start); end
        checks++; if (h_total_meas !== 0 || v_total_meas !== 0) begin errors++; $display("FAIL reset_meas: got %0d,%0d expected 0,0", h_total_meas, v_total_meas); end
        @(negedge clk); rst_n = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nominal();
        clear_obs();
        repeat (3) drive_frame(-1, 0);
        checks++; if (lock_rise_at !== 3) begin errors++; $display("FAIL lock_at_boundary: got %0d expected 3", lock_rise_at); end
        checks++; if (n_err_pulse !== 0) begin errors++; $display("FAIL nominal_err_pulses: got %0d expected 0", n_err_pulse); end
        checks++; if (h_total_meas !== 10'(HT)) begin errors++; $display("FAIL nominal_h_total: got %0d expected %0d", h_total_meas, HT); end
        checks++; if (v_total_meas !== 10'(VT)) begin errors++; $display("FAIL nominal_v_total: got %0d expected %0d", v_total_meas, VT); end
    endtask

    task automatic test_active_window();
        clear_obs();
        drive_frame(-1, 1);
        checks++; if (mark_x !== 0 || mark_y !== 0) begin errors++; $display("FAIL first_active_pixel: got %0d,%0d expected 0,0", mark_x, mark_y); end
        checks++; if (n_valid !== HA * VA) begin errors++; $display("FAIL active_count: got %0d expected %0d", n_valid, HA * VA); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL window_locked: got %b expected 1", locked); end
    endtask

    task automatic test_short_line();
        int sl;
        clear_obs();
        sl = $urandom_range(1, VT - 2);
        drive_frame(sl, 0);
        checks++; if (n_err_pulse !== 1) begin errors++; $display("FAIL short_err_pulses: got %0d expected 1", n_err_pulse); end
        checks++; if (hm_at_err !== 10'(HT - 1)) begin errors++; $display("FAIL short_h_meas: got %0d expected %0d", hm_at_err, HT - 1); end
        checks++; if (locked_at_err !== 1'b0) begin errors++; $display("FAIL short_unlock: got %b expected 0", locked_at_err); end
        repeat (2) drive_frame(-1, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b expected 0", locked); end
        drive_frame(-1, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b expected 1", locked); end
    endtask

    task automatic test_saturation();
        clear_obs();
        for (int i = 0; i < 1100; i++) drive_px(1'b1, 1'b1, rand_rgb());
        checks++; if (n_err_pulse !== 1) begin errors++; $display("FAIL sat_err_pulses: got %0d expected 1", n_err_pulse); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sat_unlock: got %b expected 0", locked); end
        repeat (3) drive_frame(-1, 0);
        checks++; if (locked !== 1'b1 || n_err_pulse !== 1) begin errors++; $display("FAIL sat_recover: got locked=%b errs=%0d expected 1,1", locked, n_err_pulse); end
    endtask

    task automatic test_reset_mid();
        int k;
        k = $urandom_range(VS + 1, VT - 3);
        for (int l = 0; l < k; l++) drive_line(l, HT, HT, 0);
        drive_line(k, HT, HT / 2, 0);
        #3 rst_n = 0;
        #1;
        checks++; if (locked !== 0 || pix_valid !== 0 || pix_x !== 0 || pix_y !== 0 || rgb_out !== 0) begin errors++; $display("FAIL async_reset_pix: got lk=%b v=%b x=%0d y=%0d rgb=%h expected all 0", locked, pix_valid, pix_x, pix_y, rgb_out); end
        checks++; if (h_total_meas !== 0 || v_total_meas !== 0 || timing_err !== 0 || frame_start !== 0) begin errors++; $display("FAIL async_reset_meas: got %0d,%0d,%b,%b expected 0,0,0,0", h_total_meas, v_total_meas, timing_err, frame_start); end
        hsync_in = 1; vsync_in = 1; rgb_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        clear_obs();
        for (int l = k + 1; l < VT; l++) drive_line(l, HT, HT, 0);
        repeat (3) drive_frame(-1, 0);
        checks++; if (lock_rise_at !== 3) begin errors++; $display("FAIL lock_after_reset: got %0d expected 3", lock_rise_at); end
    endtask

`ifdef VGA_RX_FRAME_CRC_EN
    task automatic test_crc();
        const_zero = 1;
        crc_hist.delete();
        repeat (3) drive_frame(-1, 0);
        drive_line(0, HT, 2, 0);
        const_zero = 0;
        checks++;
        if (crc_hist.size() < 3 || crc_hist[crc_hist.size() - 1] !== crc_hist[crc_hist.size() - 2]) begin
            errors++;
            $display("FAIL crc_repeat: got %0d boundaries, last values differ, expected equal", crc_hist.size());
        end
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        const_zero = 0;
        clear_obs();
        test_reset();
        test_nominal();
        test_active_window();
        test_short_line();
        test_saturation();
        test_reset_mid();
`ifdef VGA_RX_FRAME_CRC_EN
        test_crc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
